// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage MiniRiscV pipeline.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_ecall,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             io_ack,
  output logic             pc_stall,
  output logic             if_stall,
  output logic             if_clear,
  output logic             id_clear,
  output logic             ecall_busy,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_GO   = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   ack_q;
  logic   ack_rise;
  logic   lu;

  assign ack_rise = io_ack & ~ack_q;
  assign lu = ex_MemRead & (ex_rd != 5'd0) &
              ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
      ack_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ack_q <= io_ack;
    end
  end

  // A redirect squashes whatever sits in ID, including a waiting ecall.
  always_comb begin
    state_nxt = S_RUN;
    pc_stall  = 1'b0;
    if_stall  = 1'b0;
    if_clear  = 1'b0;
    id_clear  = 1'b0;
    if (rst) begin
      if_clear = 1'b1;
      id_clear = 1'b1;
    end else if (ex_redirect) begin
      if_clear  = 1'b1;
      id_clear  = 1'b1;
      state_nxt = S_RUN;
    end else begin
      case (state)
        S_RUN: begin
          if (id_ecall) begin
            state_nxt = S_WAIT;
          end else if (lu) begin
            pc_stall = 1'b1;
            if_stall = 1'b1;
            id_clear = 1'b1;
          end
        end
        S_WAIT: begin
          pc_stall  = 1'b1;
          if_stall  = 1'b1;
          id_clear  = 1'b1;
          state_nxt = ack_rise ? S_GO : S_WAIT;
        end
        S_GO:    state_nxt = S_RUN;
        default: state_nxt = S_RUN;
      endcase
    end
  end

  assign state_o    = state;
  assign ecall_busy = (state == S_WAIT);

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (pc_stall)
        stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (ex_redirect)
        flush_q <= flush_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
